// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the run/halt/step sequencer: FSM encoding, halt causes
// and the control-unit state codes the sequencer watches.
package exec_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_HALT  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } exec_state_t;

  typedef enum logic [1:0] {
    CAUSE_RESET = 2'd0,
    CAUSE_USER  = 2'd1,
    CAUSE_STEP  = 2'd2,
    CAUSE_BREAK = 2'd3
  } halt_cause_t;

  localparam int         CU_STATE_W = 5;
  localparam logic [4:0] CU_FETCH   = 5'd0;

endpackage

// File: rtl/exec_counters.sv
// Cycle and retired-instruction counters for the debug/IO board; both wrap freely.
module exec_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             cyc_inc,
  input  logic             ins_inc,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else if (clr) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else if (en) begin
      if (cyc_inc) cycle_cnt <= cycle_cnt + 1'b1;
      if (ins_inc) instr_cnt <= instr_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/exec_ctrl.sv
// Run/halt/step sequencer: owns the datapath clock-enable and reset, stops on
// instruction boundaries or a PC breakpoint, and keeps cycle/instruction counts.
module exec_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter logic [4:0] FETCH_STATE  = CU_FETCH,
  parameter int         RESET_CYCLES = 4,
  parameter bit         AUTO_RUN     = 1'b0,
  parameter int         CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sw_reset,
  input  logic             run,
  input  logic             halt,
  input  logic             step,
  input  logic [4:0]       state_cur,
  input  logic [4:0]       state_next,
  input  logic [15:0]      pc,
  input  logic [15:0]      bp_addr,
  input  logic             bp_en,
  output logic             cpu_en,
  output logic             cpu_reset,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RESET_CYCLES - 1);

  exec_state_t      state;
  halt_cause_t      cause_q;
  logic [RST_W-1:0] rst_cnt;
  logic             skip;
  logic             step_mark;
  logic             in_rst;
  logic             bp_hit;
  logic             boundary;

  assign in_rst     = (state == ST_RST);
  assign cpu_reset  = in_rst;
  assign halted     = (state == ST_HALT);
  assign halt_cause = cause_q;

  // skip masks the breakpoint for the instruction we resume on
  assign bp_hit   = bp_en & ~skip & (state_cur == FETCH_STATE) & (pc == bp_addr);
  assign boundary = cpu_en & (state_next == FETCH_STATE) & (state_cur != FETCH_STATE);

  always_comb begin
    cpu_en = 1'b1;
    case (state)
      ST_RST:   cpu_en = 1'b1;
      ST_HALT:  cpu_en = 1'b0;
      ST_RUN:   cpu_en = ~bp_hit;
      ST_DRAIN: cpu_en = 1'b1;
      default:  cpu_en = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_RST;
      rst_cnt   <= RST_LOAD;
      skip      <= 1'b0;
      step_mark <= 1'b0;
      cause_q   <= CAUSE_RESET;
    end else if (sw_reset) begin
      state     <= ST_RST;
      rst_cnt   <= RST_LOAD;
      skip      <= 1'b0;
      step_mark <= 1'b0;
      cause_q   <= CAUSE_RESET;
    end else begin
      if (boundary) skip <= 1'b0;
      case (state)
        ST_RST: begin
          if (rst_cnt == '0) begin
            state   <= AUTO_RUN ? ST_RUN : ST_HALT;
            cause_q <= CAUSE_RESET;
          end else begin
            rst_cnt <= rst_cnt - 1'b1;
          end
        end
        ST_HALT: begin
          if (run) begin
            state <= ST_RUN;
            skip  <= 1'b1;
          end else if (step) begin
            state     <= ST_DRAIN;
            skip      <= 1'b1;
            step_mark <= 1'b1;
          end
        end
        ST_RUN: begin
          if (bp_hit) begin
            state   <= ST_HALT;
            cause_q <= CAUSE_BREAK;
          end else if (halt) begin
            state     <= ST_DRAIN;
            step_mark <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (boundary) begin
            state   <= ST_HALT;
            cause_q <= step_mark ? CAUSE_STEP : CAUSE_USER;
          end
        end
        default: state <= ST_RST;
      endcase
    end
  end

  exec_counters #(
    .CNT_W(CNT_W)
  ) u_counters (
    .clk      (clk),
    .reset    (reset),
    .clr      (sw_reset | in_rst),
    .en       (~in_rst),
    .cyc_inc  (cpu_en & ~cpu_reset),
    .ins_inc  (boundary),
    .cycle_cnt(cycle_cnt),
    .instr_cnt(instr_cnt)
  );

endmodule

// File: tb/tb_exec_ctrl.sv
// Bench for exec_ctrl: a toy multi-cycle datapath with random instruction lengths,
// checked against an instruction-level model of run/halt/step/breakpoint behaviour.
module tb_exec_ctrl;

  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          reset, sw_reset, run, halt, step, bp_en;
  logic [4:0]    state_cur, state_next;
  logic [15:0]   pc, bp_addr;
  logic          cpu_en, cpu_reset, halted;
  logic [1:0]    halt_cause;
  logic [CW-1:0] cycle_cnt, instr_cnt;

  int vectors = 0;
  int errors  = 0;

  // instruction-level reference state
  int m_pc, m_cycles, m_instrs;

  logic [2:0]  len_tab [0:255];
  logic [4:0]  cu  = 5'd0;
  logic [15:0] dpc = 16'd0;
  logic [4:0]  cu_last;

  exec_ctrl #(
    .FETCH_STATE (5'd0),
    .RESET_CYCLES(4),
    .AUTO_RUN    (1'b0),
    .CNT_W       (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sw_reset  (sw_reset),
    .run       (run),
    .halt      (halt),
    .step      (step),
    .state_cur (state_cur),
    .state_next(state_next),
    .pc        (pc),
    .bp_addr   (bp_addr),
    .bp_en     (bp_en),
    .cpu_en    (cpu_en),
    .cpu_reset (cpu_reset),
    .halted    (halted),
    .halt_cause(halt_cause),
    .cycle_cnt (cycle_cnt),
    .instr_cnt (instr_cnt)
  );

  initial forever #5 clk = ~clk;

  // toy datapath: instruction at pc walks states 0..len-1, then back to fetch
  assign cu_last    = {2'b00, len_tab[dpc[7:0]]} - 5'd1;
  assign state_cur  = cu;
  assign pc         = dpc;
  assign state_next = (cu == cu_last) ? 5'd0 : cu + 5'd1;

  always @(posedge clk) begin
    if (cpu_reset) begin
      cu  <= 5'd0;
      dpc <= 16'd0;
    end else if (cpu_en) begin
      cu <= state_next;
      if (state_next == 5'd0) dpc <= dpc + 16'd1;
    end
  end

  function automatic int ilen(input int p);
    return int'(len_tab[p & 255]);
  endfunction

  task automatic test_reset();
    int n;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({cpu_reset, cpu_en, halted, halt_cause, cycle_cnt, instr_cnt} !== {1'b1, 1'b1, 1'b0, 2'd0, {CW{1'b0}}, {CW{1'b0}}}) begin
      errors++;
      $display("FAIL reset_hold: got rst=%b en=%b hlt=%b cause=%0d cyc=%0d ins=%0d, expected 1 1 0 0 0 0",
               cpu_reset, cpu_en, halted, halt_cause, cycle_cnt, instr_cnt);
    end
    reset = 1'b0;
    n = 0;
    while (cpu_reset && n < 20) begin
      n++;
      @(negedge clk);
    end
    vectors++;
    if (n !== 4) begin
      errors++;
      $display("FAIL reset_len: got %0d cycles of cpu_reset, expected 4", n);
    end
    m_pc = 0; m_cycles = 0; m_instrs = 0;
    vectors++;
    if ({halted, cpu_en, halt_cause, cycle_cnt, instr_cnt} !== {1'b1, 1'b0, 2'd0, {CW{1'b0}}, {CW{1'b0}}}) begin
      errors++;
      $display("FAIL reset_halt: got hlt=%b en=%b cause=%0d cyc=%0d ins=%0d, expected 1 0 0 0 0",
               halted, cpu_en, halt_cause, cycle_cnt, instr_cnt);
    end
  endtask

  task automatic test_step();
    int l, n_en;
    l = ilen(m_pc);
    @(negedge clk) step = 1'b1;
    @(negedge clk) step = 1'b0;
    n_en = 0;
    for (int i = 0; i < 50 && !halted; i++) begin
      if (cpu_en) n_en++;
      @(negedge clk);
    end
    m_cycles += l; m_instrs += 1; m_pc += 1;
    vectors++;
    if (n_en !== l) begin
      errors++;
      $display("FAIL step_en_cycles: got %0d, expected %0d", n_en, l);
    end
    vectors++;
    if ({halted, cpu_en, halt_cause, state_cur} !== {1'b1, 1'b0, 2'd2, 5'd0}) begin
      errors++;
      $display("FAIL step_halt: got hlt=%b en=%b cause=%0d cur=%0d, expected 1 0 2 0",
               halted, cpu_en, halt_cause, state_cur);
    end
    vectors++;
    if ({cycle_cnt, instr_cnt, pc} !== {m_cycles[CW-1:0], m_instrs[CW-1:0], 16'(m_pc)}) begin
      errors++;
      $display("FAIL step_counts: got cyc=%0d ins=%0d pc=%0h, expected %0d %0d %0h",
               cycle_cnt, instr_cnt, pc, m_cycles[CW-1:0], m_instrs[CW-1:0], m_pc);
    end
  endtask

  // halt pulse lands in enabled cycle k+1; stop at the first instruction end >= k+2
  task automatic test_run_halt(input int k, input bit with_step, input string name);
    int s, j;
    s = 0; j = 0;
    while (s < k + 2) begin
      s += ilen(m_pc + j);
      j++;
    end
    @(negedge clk) begin run = 1'b1; step = with_step; end
    @(negedge clk) begin run = 1'b0; step = 1'b0; end
    repeat (k) @(negedge clk);
    halt = 1'b1;
    @(negedge clk) halt = 1'b0;
    for (int i = 0; i < 200 && !halted; i++) @(negedge clk);
    m_cycles += s; m_instrs += j; m_pc += j;
    vectors++;
    if ({halted, cpu_en, halt_cause, state_cur} !== {1'b1, 1'b0, 2'd1, 5'd0}) begin
      errors++;
      $display("FAIL %s_halt: got hlt=%b en=%b cause=%0d cur=%0d, expected 1 0 1 0",
               name, halted, cpu_en, halt_cause, state_cur);
    end
    vectors++;
    if ({cycle_cnt, instr_cnt, pc} !== {m_cycles[CW-1:0], m_instrs[CW-1:0], 16'(m_pc)}) begin
      errors++;
      $display("FAIL %s_counts: got cyc=%0d ins=%0d pc=%0h, expected %0d %0d %0h",
               name, cycle_cnt, instr_cnt, pc, m_cycles[CW-1:0], m_instrs[CW-1:0], m_pc);
    end
  endtask

  task automatic test_breakpoint();
    int target, s, found;
    target = (m_pc < 16) ? 16 : m_pc + 2;
    s = 0;
    for (int p = m_pc; p < target; p++) s += ilen(p);
    bp_addr = 16'(target);
    bp_en   = 1'b1;
    @(negedge clk) run = 1'b1;
    @(negedge clk) run = 1'b0;
    found = 0;
    for (int i = 0; i < 300; i++) begin
      if (pc == bp_addr && state_cur == 5'd0) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    vectors++;
    if ({found[0], cpu_en, halted} !== 3'b100) begin
      errors++;
      $display("FAIL bp_same_cycle: got found=%0d en=%b hlt=%b, expected 1 0 0", found, cpu_en, halted);
    end
    @(negedge clk);
    m_cycles += s; m_instrs += target - m_pc; m_pc = target;
    vectors++;
    if ({halted, halt_cause, cycle_cnt, instr_cnt, pc} !== {1'b1, 2'd3, m_cycles[CW-1:0], m_instrs[CW-1:0], 16'(m_pc)}) begin
      errors++;
      $display("FAIL bp_halt: got hlt=%b cause=%0d cyc=%0d ins=%0d pc=%0h, expected 1 3 %0d %0d %0h",
               halted, halt_cause, cycle_cnt, instr_cnt, pc, m_cycles[CW-1:0], m_instrs[CW-1:0], m_pc);
    end
    // resume on the breakpointed instruction must not trap again
    test_run_halt($urandom_range(0, 4), 1'b0, "bp_resume");
    s = ilen(m_pc) + ilen(m_pc + 1);
    bp_addr = 16'(m_pc + 2);
    @(negedge clk) run = 1'b1;
    @(negedge clk) run = 1'b0;
    for (int i = 0; i < 200 && !halted; i++) @(negedge clk);
    m_cycles += s; m_instrs += 2; m_pc += 2;
    vectors++;
    if ({halted, halt_cause, cycle_cnt, instr_cnt, pc} !== {1'b1, 2'd3, m_cycles[CW-1:0], m_instrs[CW-1:0], 16'(m_pc)}) begin
      errors++;
      $display("FAIL bp_revisit: got hlt=%b cause=%0d cyc=%0d ins=%0d pc=%0h, expected 1 3 %0d %0d %0h",
               halted, halt_cause, cycle_cnt, instr_cnt, pc, m_cycles[CW-1:0], m_instrs[CW-1:0], m_pc);
    end
    bp_en = 1'b0;
  endtask

  task automatic test_halt_vs_bp();
    int l;
    l = ilen(m_pc);
    bp_addr = 16'(m_pc + 1);
    bp_en   = 1'b1;
    @(negedge clk) run = 1'b1;
    @(negedge clk) run = 1'b0;
    repeat (l) @(negedge clk);
    halt = 1'b1;
    @(negedge clk) halt = 1'b0;
    for (int i = 0; i < 50 && !halted; i++) @(negedge clk);
    m_cycles += l; m_instrs += 1; m_pc += 1;
    vectors++;
    if ({halted, halt_cause, cycle_cnt, instr_cnt, pc} !== {1'b1, 2'd3, m_cycles[CW-1:0], m_instrs[CW-1:0], 16'(m_pc)}) begin
      errors++;
      $display("FAIL halt_vs_bp: got hlt=%b cause=%0d cyc=%0d ins=%0d pc=%0h, expected 1 3 %0d %0d %0h",
               halted, halt_cause, cycle_cnt, instr_cnt, pc, m_cycles[CW-1:0], m_instrs[CW-1:0], m_pc);
    end
    bp_en = 1'b0;
  endtask

  task automatic test_sw_reset_drain();
    int n;
    @(negedge clk) step = 1'b1;
    @(negedge clk) begin step = 1'b0; sw_reset = 1'b1; end
    @(negedge clk) sw_reset = 1'b0;
    vectors++;
    if ({cpu_reset, cpu_en, halted, halt_cause, cycle_cnt, instr_cnt} !== {1'b1, 1'b1, 1'b0, 2'd0, {CW{1'b0}}, {CW{1'b0}}}) begin
      errors++;
      $display("FAIL swrst_enter: got rst=%b en=%b hlt=%b cause=%0d cyc=%0d ins=%0d, expected 1 1 0 0 0 0",
               cpu_reset, cpu_en, halted, halt_cause, cycle_cnt, instr_cnt);
    end
    n = 0;
    while (cpu_reset && n < 20) begin
      n++;
      @(negedge clk);
    end
    m_pc = 0; m_cycles = 0; m_instrs = 0;
    vectors++;
    if (n !== 4) begin
      errors++;
      $display("FAIL swrst_len: got %0d cycles of cpu_reset, expected 4", n);
    end
    vectors++;
    if ({halted, halt_cause, cycle_cnt, instr_cnt, pc} !== {1'b1, 2'd0, {CW{1'b0}}, {CW{1'b0}}, 16'd0}) begin
      errors++;
      $display("FAIL swrst_halt: got hlt=%b cause=%0d cyc=%0d ins=%0d pc=%0h, expected 1 0 0 0 0",
               halted, halt_cause, cycle_cnt, instr_cnt, pc);
    end
  endtask

  task automatic test_async_reset();
    int n;
    @(negedge clk) run = 1'b1;
    @(negedge clk) run = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({cpu_reset, cpu_en, halted, halt_cause, cycle_cnt, instr_cnt} !== {1'b1, 1'b1, 1'b0, 2'd0, {CW{1'b0}}, {CW{1'b0}}}) begin
      errors++;
      $display("FAIL async_reset: got rst=%b en=%b hlt=%b cause=%0d cyc=%0d ins=%0d, expected 1 1 0 0 0 0",
               cpu_reset, cpu_en, halted, halt_cause, cycle_cnt, instr_cnt);
    end
    @(negedge clk) reset = 1'b0;
    n = 0;
    while (cpu_reset && n < 20) begin
      n++;
      @(negedge clk);
    end
    vectors++;
    if ({n[3:0], halted, cpu_en} !== {4'd4, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL async_release: got rstlen=%0d hlt=%b en=%b, expected 4 1 0", n, halted, cpu_en);
    end
  endtask

  initial begin
    reset = 1'b1; sw_reset = 1'b0; run = 1'b0; halt = 1'b0; step = 1'b0;
    bp_en = 1'b0; bp_addr = 16'd0;
    for (int i = 0; i < 256; i++) len_tab[i] = 3'($urandom_range(2, 5));
    len_tab[0] = 3'd3;
    len_tab[1] = 3'd4;
    test_reset();
    test_step();
    test_step();
    for (int r = 0; r < 3; r++) test_run_halt($urandom_range(0, 5), 1'b0, "run_halt");
    test_breakpoint();
    test_halt_vs_bp();
    test_run_halt(ilen(m_pc) + $urandom_range(0, 2), 1'b1, "run_step");
    test_run_halt(70, 1'b0, "wrap");
    test_sw_reset_drain();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/exec_ctrl.md
Name: exec_ctrl

Overview:
- Run/halt/step sequencer for the multi-cycle datapath.
- Owns the datapath clock-enable (cpu_en) and the datapath reset (cpu_reset).
- Watches the control unit's current/next state codes to find instruction boundaries, and supports a single PC breakpoint.
- Provides cycle and retired-instruction counters for the debug/IO board logic.

Parameters:
- FETCH_STATE, 5'd0: control-unit state code of the fetch state.
- RESET_CYCLES, 4: number of cycles cpu_reset is held; minimum 1.
- AUTO_RUN, 0: 1 = go to RUN after reset, 0 = go to HALT.
- CNT_W, 32: width of each counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- sw_reset  in  1  synchronous pulse; restarts the reset sequence.
- run  in  1  single-cycle pulse; start free-running.
- halt  in  1  single-cycle pulse; stop at the next instruction boundary.
- step  in  1  single-cycle pulse; execute exactly one instruction.
- state_cur  in  5  control-unit current state.
- state_next  in  5  control-unit next state.
- pc  in  16  current PC value.
- bp_addr  in  16  breakpoint address.
- bp_en  in  1  breakpoint enable.
- cpu_en  out  1  datapath clock-enable.
- cpu_reset  out  1  datapath reset.
- halted  out  1  high in HALT.
- halt_cause  out  2  0 = reset, 1 = user halt, 2 = step done, 3 = breakpoint.
- cycle_cnt  out  CNT_W  count of enabled cycles.
- instr_cnt  out  CNT_W  count of retired instructions.

Behaviour:
- FSM states: RST, HALT, RUN, DRAIN.
- Async reset values: state = RST, rst_cnt = RESET_CYCLES-1, skip = 0, halt_cause = 0, both counters = 0.
- Reset-time outputs: cpu_reset = 1, cpu_en = 1, halted = 0.
- boundary = cpu_en & (state_next == FETCH_STATE) & (state_cur != FETCH_STATE). This is combinational.
- bp_hit = bp_en & ~skip & (state_cur == FETCH_STATE) & (pc == bp_addr). This is combinational.
- RST: cpu_reset = 1, cpu_en = 1. rst_cnt decrements each cycle. When rst_cnt == 0, go to RUN if AUTO_RUN, else HALT. Counters are held at 0.
- HALT: cpu_en = 0, halted = 1.
  - run -> RUN, set skip.
  - step -> DRAIN, set skip, mark step.
  - If run and step arrive together, run wins.
- RUN: cpu_en = ~bp_hit.
  - bp_hit -> HALT, cause 3. The fetch is suppressed in that same cycle.
  - else halt -> DRAIN, mark user.
  - If halt and bp_hit arrive together, bp_hit wins.
- DRAIN: cpu_en = 1. On boundary -> HALT; cause = 2 if marked step, else 1. run/halt/step are ignored in DRAIN.
- The datapath lands in FETCH_STATE with cpu_en = 0 on the cycle HALT is entered.
- skip clears on the first boundary after it is set. This lets a resume from a breakpoint execute the breakpointed instruction.
- sw_reset: any state -> RST. It reloads rst_cnt, clears the counters and skip, and sets cause to 0. It has priority over every other input.
- cycle_cnt increments each cycle with cpu_en & ~cpu_reset.
- instr_cnt increments on boundary outside RST.
- Both counters wrap modulo 2^CNT_W.
- halt_cause is registered and updates only on entry to HALT or RST.
- Pulses on run/halt/step that arrive in RST are dropped.

Decomposition:
- Shared package holds:
  - the FSM state encoding (RST/HALT/RUN/DRAIN, 2 bits);
  - the halt_cause constants (CAUSE_RESET/USER/STEP/BREAK);
  - FETCH_STATE, kept alongside the control-unit state codes.
- One natural sub-module: exec_counters. It holds cycle_cnt and instr_cnt, with enable, increment and clear inputs.
- The FSM stays in exec_ctrl.

Test Plan:
1. Reset with AUTO_RUN = 0, RESET_CYCLES = 4.
   - cpu_reset = 1 for exactly 4 cycles, then halted = 1, cpu_en = 0, cause = 0, counters = 0.
2. From HALT, pulse step; model walks states 0->1->2->0.
   - cpu_en high for 3 cycles, then halted = 1, cause = 2, instr_cnt = 1, cycle_cnt = 3.
3. Pulse run, then pulse halt mid-instruction (state_cur = 2, next = 3, then 3->0).
   - Stops after the 3->0 edge with cause = 1, datapath at fetch, instr_cnt advanced by 1 from the halt point.
4. bp_en = 1, bp_addr = 16'h0010; run until pc = 16'h0010 in fetch.
   - cpu_en = 0 that same cycle, halted = 1 next cycle, cause = 3.
   - Pulse run: the instruction at 16'h0010 executes, and the breakpoint is not re-hit until the next visit.
5. halt and bp_hit in the same cycle -> cause = 3.
   - run + step together in HALT -> RUN, not DRAIN.
6. sw_reset during DRAIN -> RST next cycle, cpu_reset = 1 for 4 cycles, counters = 0, cause = 0.
   - Async reset asserted mid-RUN -> all outputs at reset values with no clock edge.
